// File: rtl/fifo_pkg.sv
// Shared types for the sync_fifo read-side drain stage.
// Holds the default data width, the occupancy type and the buffer depth.
package fifo_pkg;

  localparam int DATA_W    = 8;
  localparam int BUF_DEPTH = 2;

  typedef logic [1:0] occ_t;

endpackage

// File: rtl/fifo_drain_buf.sv
// Two-entry in-order output buffer (head/tail) for the drain stage.
// Head is the word presented downstream; tail queues behind it.
module fifo_drain_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output occ_t                  occ,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] tail;

  // Occupancy and entry update; a push at occ=2 is always paired with a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      occ <= '0;
    end else begin
      case (occ)
        2'd0: begin
          if (push) begin
            head <= din;
            occ  <= 2'd1;
          end
        end
        2'd1: begin
          case ({push, pop})
            2'b11: head <= din;
            2'b10: begin
              tail <= din;
              occ  <= 2'd2;
            end
            2'b01: occ <= 2'd0;
            default: ;
          endcase
        end
        2'd2: begin
          if (pop) begin
            head <= tail;
            if (push) tail <= din;
            else      occ  <= 2'd1;
          end
        end
        default: occ <= '0;
      endcase
    end
  end

endmodule

// File: rtl/fifo_stream_drain.sv
// sync_fifo rd_en/dout/empty to valid/ready stream with 2-entry buffer.
// Define FIFO_DRAIN_STATS_EN to add the stat_words/stat_stalls counters.
module fifo_stream_drain
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W
`ifdef FIFO_DRAIN_STATS_EN
  ,
  parameter int CNT_WIDTH  = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stat_words,
  output logic [CNT_WIDTH-1:0]  stat_stalls
`endif
);

  occ_t       occ;
  logic       inflight;
  logic       pop;
  logic [2:0] level;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;

  // Slots committed after this cycle: buffered + returning - leaving.
  assign level = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

  assign fifo_rd_en = !rst && !flush && !fifo_empty
                   && (level < 3'(BUF_DEPTH));

  // A read issued this cycle returns data on fifo_dout next cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) inflight <= 1'b0;
    else              inflight <= fifo_rd_en;
  end

  fifo_drain_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .push (inflight),
    .pop  (pop),
    .din  (fifo_dout),
    .occ  (occ),
    .head (m_data)
  );

`ifdef FIFO_DRAIN_STATS_EN
  // Saturating delivery/stall counters, cleared by reset only.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_words  <= '0;
      stat_stalls <= '0;
    end else begin
      if (pop && (stat_words != '1))
        stat_words <= stat_words + 1'b1;
      if (m_valid && !m_ready && (stat_stalls != '1))
        stat_stalls <= stat_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Bench for fifo_stream_drain: queue-based sync_fifo and stream model,
// directed scenarios followed by randomized traffic, flushes and resets.
module tb_fifo_stream_drain;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout = '0;
  logic       m_ready = 1'b0;
  logic       fifo_rd_en;
  logic       m_valid;
  logic [7:0] m_data;
`ifdef FIFO_DRAIN_STATS_EN
  logic [15:0] stat_words;
  logic [15:0] stat_stalls;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fq[$];
  logic [7:0] vis[$];
  bit         m_infl = 0;
  logic [7:0] m_word = '0;
  bit         pend = 0;
  logic [7:0] pend_w = '0;
  int         reads = 0;
  logic [7:0] last_out = '0;
  bit         rst_prev = 1;
  int         s_words = 0;
  int         s_stalls = 0;

  always #5 clk = ~clk;

  fifo_stream_drain dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef FIFO_DRAIN_STATS_EN
    ,
    .stat_words (stat_words),
    .stat_stalls(stat_stalls)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit rdy, input bit fl, input bit r);
    bit exp_v;
    bit exp_rd;
    bit p;
    int lvl;
    @(negedge clk);
    rst        = r;
    flush      = fl;
    m_ready    = rdy;
    fifo_dout  = pend ? pend_w : 8'($urandom);
    fifo_empty = (fq.size() == 0);
    #1;
    exp_v  = (vis.size() != 0);
    p      = exp_v && rdy;
    lvl    = vis.size() + int'(m_infl) - int'(p);
    exp_rd = !r && !fl && (fq.size() != 0) && (lvl < 2);
    chk("rd_en", fifo_rd_en, exp_rd);
    chk("m_valid", m_valid, exp_v);
    if (exp_v) chk("m_data", m_data, vis[0]);
    if (r && rst_prev) chk("rst_data", m_data, 0);
`ifdef FIFO_DRAIN_STATS_EN
    chk("stat_words", stat_words, s_words);
    chk("stat_stalls", stat_stalls, s_stalls);
`endif
    if (p) begin
      last_out = vis.pop_front();
      if (s_words < 16'hFFFF) s_words++;
    end
    if (exp_v && !rdy && s_stalls < 16'hFFFF) s_stalls++;
    if (r || fl) vis.delete();
    else if (m_infl) vis.push_back(m_word);
    if (r) begin
      s_words  = 0;
      s_stalls = 0;
    end
    m_infl = 0;
    pend   = 0;
    if (fifo_rd_en && fq.size() != 0) begin
      pend_w = fq.pop_front();
      pend   = 1;
      m_infl = 1;
      m_word = pend_w;
      reads++;
    end
    rst_prev = r;
  endtask

  initial begin
    repeat (2) @(posedge clk);

    // reset held, fifo empty
    repeat (2) step(0, 0, 1);

    // 11..88 streamed with m_ready high
    for (int i = 0; i < 8; i++) fq.push_back(8'(8'h11 * (i + 1)));
    repeat (12) step(1, 0, 0);
    chk("t2_last", last_out, 8'h88);

    // stalled downstream: only two reads issued
    reads = 0;
    for (int i = 0; i < 4; i++) fq.push_back(8'(8'h11 * (i + 1)));
    repeat (6) step(0, 0, 0);
    chk("t3_reads", reads, 2);
    chk("t3_head", m_data, 8'h11);
    repeat (8) step(1, 0, 0);
    chk("t3_last", last_out, 8'h44);

    // toggling ready with concurrent writes
    for (int i = 0; i < 12; i++) begin
      if (i < 4) fq.push_back(8'(8'hAB + i));
      step(i % 2 == 0, 0, 0);
    end
    repeat (4) step(1, 0, 0);
    chk("t4_last", last_out, 8'hAE);

    // flush with buffered and in-flight words
    fq.push_back(8'hA1);
    fq.push_back(8'hA2);
    repeat (2) step(0, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    chk("t5_valid", m_valid, 0);
    fq.push_back(8'h5A);
    repeat (6) step(1, 0, 0);
    chk("t5_next", last_out, 8'h5A);

`ifdef FIFO_DRAIN_STATS_EN
    repeat (2) step(0, 0, 1);
    for (int i = 0; i < 8; i++) fq.push_back(8'(8'h30 + i));
    repeat (3) step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    repeat (12) step(1, 0, 0);
    chk("t6_words", stat_words, 8);
    chk("t6_stalls", stat_stalls, 3);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("t6_flush_words", stat_words, 8);
    chk("t6_flush_stalls", stat_stalls, 3);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("t6_rst_words", stat_words, 0);
    chk("t6_rst_stalls", stat_stalls, 0);
`endif

    // randomized traffic, flushes and resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0 && fq.size() < 16)
        fq.push_back(8'($urandom));
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 49) == 0,
           $urandom_range(0, 499) == 0);
    end
    while (fq.size() != 0) fq.delete(0);
    repeat (20) step(1, 0, 0);
    chk("drain_valid", m_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
